// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle 32-bit ALU between two valid/ready
// requesters. A one-entry response buffer returns the tagged result and flags.
// Each requester has a saturating grant counter for performance debug.
//
// state   | meaning
// --------+----------------------------------------------------------
// r_ptr=0 | requester 0 preferred on contention (round-robin mode)
// r_ptr=1 | requester 1 preferred on contention (round-robin mode)
// empty   | r_rsp_valid=0, any granted op is accepted
// full    | r_rsp_valid=1, accepts only when rsp_ready drains it
module alu_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_f,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_f,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_carry,
  output logic             rsp_negative,
  output logic             rsp_err,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  logic             r_ptr;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [31:0]      r_rsp_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_carry;
  logic             r_neg;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_can_accept;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_accept;
  logic [31:0]      w_a;
  logic [31:0]      w_b;
  logic [2:0]       w_f;
  logic             w_sub;
  logic [31:0]      w_b_eff;
  logic [32:0]      w_sum;
  logic             w_add_ovf;
  logic [31:0]      w_result;
  logic             w_carry;
  logic             w_ovf;
  logic             w_err;

  assign w_can_accept = !r_rsp_valid || rsp_ready;

  // Requester 1 wins when alone, or on contention when round-robin points at it.
  assign w_gnt1 = req1_valid && (!req0_valid || (RR_EN && r_ptr));
  assign w_gnt0 = req0_valid && !w_gnt1;

  // Ready is held low during reset even though the buffer reads empty then.
  assign req0_ready = rst_n && w_gnt0 && w_can_accept;
  assign req1_ready = rst_n && w_gnt1 && w_can_accept;
  assign w_accept   = req0_ready || req1_ready;

  assign w_a = w_gnt1 ? req1_a : req0_a;
  assign w_b = w_gnt1 ? req1_b : req0_b;
  assign w_f = w_gnt1 ? req1_f : req0_f;

  // Shared adder: sub and slt compute a + ~b + 1 so carry=1 means no borrow.
  assign w_sub     = (w_f == 3'b001) || (w_f == 3'b101);
  assign w_b_eff   = w_sub ? ~w_b : w_b;
  assign w_sum     = {1'b0, w_a} + {1'b0, w_b_eff} + {32'b0, w_sub};
  assign w_add_ovf = (w_a[31] == w_b_eff[31]) && (w_sum[31] != w_a[31]);

  // ALU function decode; illegal codes zero the result but keep the adder flags.
  always_comb begin
    w_result = 32'b0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    w_err    = 1'b0;
    case (w_f)
      3'b000, 3'b001: begin
        w_result = w_sum[31:0];
        w_carry  = w_sum[32];
        w_ovf    = w_add_ovf;
      end
      3'b010: w_result = w_a & w_b;
      3'b011: w_result = w_a | w_b;
      3'b101: begin
        w_result = {31'b0, w_add_ovf ^ w_sum[31]};
        w_carry  = w_sum[32];
        w_ovf    = w_add_ovf;
      end
      default: begin
        w_result = 32'b0;
        w_carry  = w_sum[32];
        w_ovf    = w_add_ovf;
        w_err    = 1'b1;
      end
    endcase
  end

  // Response buffer: load on accept (even while draining), clear on a bare drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= 32'b0;
      r_zero       <= 1'b0;
      r_ovf        <= 1'b0;
      r_carry      <= 1'b0;
      r_neg        <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_gnt1;
      r_rsp_result <= w_result;
      r_zero       <= (w_result == 32'b0);
      r_ovf        <= w_ovf;
      r_carry      <= w_carry;
      r_neg        <= w_result[31];
      r_err        <= w_err;
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  // Round-robin pointer moves to the other requester after each accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= ~w_gnt1;
    end
  end

  // Saturating grant counters, one per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (req0_ready && (r_cnt0 != {CNT_W{1'b1}})) r_cnt0 <= r_cnt0 + 1'b1;
      if (req1_ready && (r_cnt1 != {CNT_W{1'b1}})) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp_id;
  assign rsp_result   = r_rsp_result;
  assign rsp_zero     = r_zero;
  assign rsp_overflow = r_ovf;
  assign rsp_carry    = r_carry;
  assign rsp_negative = r_neg;
  assign rsp_err      = r_err;
  assign grant_cnt0   = r_cnt0;
  assign grant_cnt1   = r_cnt1;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of the shared-ALU arbiter. Two instances
// share stimulus: a round-robin one (16-bit counters) and a fixed-priority
// one with 2-bit counters so grant-counter saturation is reachable.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [2:0]  req0_f;
  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [2:0]  req1_f;
  logic        rsp_ready;

  logic        r_rdy0, r_rdy1, r_valid, r_id, r_zero, r_ovf, r_carry, r_neg, r_err;
  logic [31:0] r_result;
  logic [15:0] r_cnt0, r_cnt1;
  logic        f_rdy0, f_rdy1, f_valid, f_id, f_zero, f_ovf, f_carry, f_neg, f_err;
  logic [31:0] f_result;
  logic [1:0]  f_cnt0, f_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.RR_EN(1'b1), .CNT_W(16)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r_rdy0), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
    .req1_valid(req1_valid), .req1_ready(r_rdy1), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
    .rsp_valid(r_valid), .rsp_ready(rsp_ready), .rsp_id(r_id), .rsp_result(r_result),
    .rsp_zero(r_zero), .rsp_overflow(r_ovf), .rsp_carry(r_carry), .rsp_negative(r_neg),
    .rsp_err(r_err), .grant_cnt0(r_cnt0), .grant_cnt1(r_cnt1)
  );

  alu_arbiter #(.RR_EN(1'b0), .CNT_W(2)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(f_rdy0), .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
    .req1_valid(req1_valid), .req1_ready(f_rdy1), .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
    .rsp_valid(f_valid), .rsp_ready(rsp_ready), .rsp_id(f_id), .rsp_result(f_result),
    .rsp_zero(f_zero), .rsp_overflow(f_ovf), .rsp_carry(f_carry), .rsp_negative(f_neg),
    .rsp_err(f_err), .grant_cnt0(f_cnt0), .grant_cnt1(f_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    #3;
    n_checks++; if (r_rdy0 !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b want 0", r_rdy0); end
    n_checks++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", r_valid); end
    n_checks++; if ({r_id, r_result, r_zero, r_ovf, r_carry, r_neg, r_err} !== 38'b0) begin n_fail++; $display("FAIL reset_rsp_fields: got id=%b res=%h flags=%b%b%b%b err=%b want all 0", r_id, r_result, r_zero, r_ovf, r_carry, r_neg, r_err); end
    n_checks++; if ({r_cnt0, r_cnt1} !== 32'b0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", r_cnt0, r_cnt1); end
    step();
    req0_valid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    req0_valid = 1'b1; req0_a = 32'h5; req0_b = 32'h3; req0_f = 3'b000;
    #1;
    n_checks++; if ({r_rdy0, r_rdy1} !== 2'b10) begin n_fail++; $display("FAIL add_ready: got %b%b want 10", r_rdy0, r_rdy1); end
    step();
    req0_valid = 1'b0;
    n_checks++; if (r_valid !== 1'b1 || r_id !== 1'b0) begin n_fail++; $display("FAIL add_valid_id: got v=%b id=%b want v=1 id=0", r_valid, r_id); end
    n_checks++; if (r_result !== 32'h8) begin n_fail++; $display("FAIL add_result: got %h want 00000008", r_result); end
    n_checks++; if ({r_zero, r_ovf, r_carry, r_neg, r_err} !== 5'b0) begin n_fail++; $display("FAIL add_flags: got zocne=%b%b%b%b%b want 00000", r_zero, r_ovf, r_carry, r_neg, r_err); end
    n_checks++; if (r_cnt0 !== 16'd1) begin n_fail++; $display("FAIL add_cnt0: got %0d want 1", r_cnt0); end
  endtask

  task automatic test_sub();
    req1_valid = 1'b1; req1_a = 32'h5; req1_b = 32'h5; req1_f = 3'b001;
    #1;
    n_checks++; if ({r_rdy0, r_rdy1} !== 2'b01) begin n_fail++; $display("FAIL sub_ready: got %b%b want 01", r_rdy0, r_rdy1); end
    step();
    req1_valid = 1'b0;
    n_checks++; if (r_valid !== 1'b1 || r_id !== 1'b1 || r_result !== 32'h0) begin n_fail++; $display("FAIL sub_rsp: got v=%b id=%b res=%h want v=1 id=1 res=0", r_valid, r_id, r_result); end
    n_checks++; if ({r_zero, r_ovf, r_carry, r_neg} !== 4'b1010) begin n_fail++; $display("FAIL sub_flags: got zocn=%b%b%b%b want 1010", r_zero, r_ovf, r_carry, r_neg); end
  endtask

  task automatic test_overflow_slt();
    req0_valid = 1'b1; req0_a = 32'h7FFF_FFFF; req0_b = 32'h1; req0_f = 3'b000;
    step();
    req0_valid = 1'b0;
    n_checks++; if (r_result !== 32'h8000_0000 || r_id !== 1'b0) begin n_fail++; $display("FAIL ovf_result: got %h id=%b want 80000000 id=0", r_result, r_id); end
    n_checks++; if ({r_zero, r_ovf, r_carry, r_neg} !== 4'b0101) begin n_fail++; $display("FAIL ovf_flags: got zocn=%b%b%b%b want 0101", r_zero, r_ovf, r_carry, r_neg); end
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h1; req1_f = 3'b101;
    step();
    req1_valid = 1'b0;
    n_checks++; if (r_result !== 32'h1 || r_id !== 1'b1) begin n_fail++; $display("FAIL slt_result: got %h id=%b want 00000001 id=1", r_result, r_id); end
    n_checks++; if ({r_zero, r_ovf, r_carry, r_neg, r_err} !== 5'b00100) begin n_fail++; $display("FAIL slt_flags: got zocne=%b%b%b%b%b want 00100", r_zero, r_ovf, r_carry, r_neg, r_err); end
    step();
    n_checks++; if (r_valid !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got rsp_valid=%b want 0", r_valid); end
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h0; req0_f = 3'b000;
    req1_valid = 1'b1; req1_a = 32'h2; req1_b = 32'h0; req1_f = 3'b000;
    rsp_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if ({r_rdy0, r_rdy1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b%b want %s", i, r_rdy0, r_rdy1, (i % 2 == 0) ? "10" : "01"); end
      n_checks++; if ({f_rdy0, f_rdy1} !== 2'b10) begin n_fail++; $display("FAIL fp_ready[%0d]: got %b%b want 10", i, f_rdy0, f_rdy1); end
      step();
      n_checks++; if (r_valid !== 1'b1 || r_id !== ((i % 2 == 0) ? 1'b0 : 1'b1) || r_result !== ((i % 2 == 0) ? 32'h1 : 32'h2)) begin n_fail++; $display("FAIL rr_rsp[%0d]: got v=%b id=%b res=%h", i, r_valid, r_id, r_result); end
      n_checks++; if (f_valid !== 1'b1 || f_id !== 1'b0 || f_result !== 32'h1) begin n_fail++; $display("FAIL fp_rsp[%0d]: got v=%b id=%b res=%h want v=1 id=0 res=1", i, f_valid, f_id, f_result); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++; if (r_cnt0 !== 16'd2 || r_cnt1 !== 16'd2) begin n_fail++; $display("FAIL rr_counts: got %0d/%0d want 2/2", r_cnt0, r_cnt1); end
    n_checks++; if (f_cnt0 !== 2'd3 || f_cnt1 !== 2'd0) begin n_fail++; $display("FAIL fp_counts_saturate: got %0d/%0d want 3/0", f_cnt0, f_cnt1); end
    step();
  endtask

  task automatic test_hold();
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4; req0_f = 3'b001;
    step();
    rsp_ready = 1'b0;
    req0_a = 32'd100; req0_b = 32'd1;
    req1_valid = 1'b1; req1_a = 32'hF0F0; req1_b = 32'h0FF7; req1_f = 3'b010;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({r_rdy0, r_rdy1, f_rdy0, f_rdy1} !== 4'b0) begin n_fail++; $display("FAIL hold_ready[%0d]: got rr=%b%b fp=%b%b want all 0", i, r_rdy0, r_rdy1, f_rdy0, f_rdy1); end
      step();
      n_checks++; if (r_valid !== 1'b1 || r_id !== 1'b0 || r_result !== 32'd6 || {r_zero, r_ovf, r_carry, r_neg} !== 4'b0010) begin n_fail++; $display("FAIL hold_stable[%0d]: got v=%b id=%b res=%h zocn=%b%b%b%b want v=1 id=0 res=6 0010", i, r_valid, r_id, r_result, r_zero, r_ovf, r_carry, r_neg); end
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0;
    #1;
    n_checks++; if ({r_rdy0, r_rdy1} !== 2'b01) begin n_fail++; $display("FAIL drain_accept_ready: got %b%b want 01", r_rdy0, r_rdy1); end
    step();
    req1_valid = 1'b0;
    n_checks++; if (r_valid !== 1'b1 || r_id !== 1'b1 || r_result !== 32'h00F0) begin n_fail++; $display("FAIL drain_accept_rsp: got v=%b id=%b res=%h want v=1 id=1 res=000000f0", r_valid, r_id, r_result); end
    step();
  endtask

  task automatic test_illegal_and_reset();
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_f = 3'b110;
    step();
    req0_valid = 1'b0;
    rsp_ready  = 1'b0;
    n_checks++; if (r_valid !== 1'b1 || r_err !== 1'b1 || r_result !== 32'h0 || r_zero !== 1'b1 || r_neg !== 1'b0) begin n_fail++; $display("FAIL illegal_rsp: got v=%b err=%b res=%h z=%b n=%b want 1 1 0 1 0", r_valid, r_err, r_result, r_zero, r_neg); end
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (r_valid !== 1'b0 || r_err !== 1'b0 || r_result !== 32'h0) begin n_fail++; $display("FAIL async_reset_rsp: got v=%b err=%b res=%h want 0 0 0", r_valid, r_err, r_result); end
    n_checks++; if ({r_cnt0, r_cnt1} !== 32'b0 || {f_cnt0, f_cnt1} !== 4'b0) begin n_fail++; $display("FAIL async_reset_counters: got rr=%0d/%0d fp=%0d/%0d want 0", r_cnt0, r_cnt1, f_cnt0, f_cnt1); end
    req0_valid = 1'b1; req0_a = 32'h11; req0_b = 32'h0; req0_f = 3'b011;
    req1_valid = 1'b1; req1_a = 32'h22; req1_b = 32'h0; req1_f = 3'b011;
    rsp_ready  = 1'b1;
    #1;
    n_checks++; if ({r_rdy0, r_rdy1} !== 2'b00) begin n_fail++; $display("FAIL in_reset_ready: got %b%b want 00", r_rdy0, r_rdy1); end
    rst_n = 1'b1;
    #1;
    n_checks++; if ({r_rdy0, r_rdy1} !== 2'b10) begin n_fail++; $display("FAIL post_reset_ptr: got %b%b want 10", r_rdy0, r_rdy1); end
    step();
    n_checks++; if (r_valid !== 1'b1 || r_id !== 1'b0 || r_result !== 32'h11 || r_err !== 1'b0) begin n_fail++; $display("FAIL post_reset_rsp: got v=%b id=%b res=%h err=%b want 1 0 00000011 0", r_valid, r_id, r_result, r_err); end
    #1;
    n_checks++; if ({r_rdy0, r_rdy1} !== 2'b01) begin n_fail++; $display("FAIL post_reset_alternate: got %b%b want 01", r_rdy0, r_rdy1); end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++; if (r_id !== 1'b1 || r_result !== 32'h22 || r_cnt0 !== 16'd1 || r_cnt1 !== 16'd1) begin n_fail++; $display("FAIL post_reset_second: got id=%b res=%h cnt=%0d/%0d want 1 00000022 1/1", r_id, r_result, r_cnt0, r_cnt1); end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_f = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_f = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_overflow_slt();
    test_back_to_back();
    test_hold();
    test_illegal_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single-cycle 32-bit ALU between two requesters (e.g. the instruction datapath and an address/branch unit).
- Each requester has a valid/ready operation port. The block arbitrates, drives one ALU instance, and registers the result and flags.
- Results are returned on one shared response channel tagged with the requester ID. A one-entry output buffer supports backpressure.
- Per-requester saturating grant counters are provided for performance debug.

Parameters:
- RR_EN, 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 always wins.
- CNT_W, 16: width of each grant counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  32  operand a.
- req0_b  in  32  operand b.
- req0_f  in  3  ALU function: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- req1_valid, req1_ready, req1_a, req1_b, req1_f: same as requester 0, for requester 1.
- rsp_valid  out  1  response buffer holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the operation.
- rsp_result  out  32  ALU result.
- rsp_zero, rsp_overflow, rsp_carry, rsp_negative  out  1 each  ALU flags.
- rsp_err  out  1  function code was illegal (100, 110, 111).
- grant_cnt0, grant_cnt1  out  CNT_W  accepted operations per requester, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): rsp_valid=0, rsp_id=0, rsp_result=0, all flags=0, rsp_err=0, grant counters=0, priority pointer=0 (requester 0 preferred).
  - A buffered response is discarded.
  - req*_ready is 0 while rst_n is low.
- can_accept = !rsp_valid || rsp_ready (combinational). The buffer is empty, or is drained this same edge.
- Grant (combinational):
  - Only one valid: grant that requester.
  - Both valid, RR_EN=1: grant the requester the pointer selects.
  - Both valid, RR_EN=0: grant requester 0.
- reqN_ready = grantN && can_accept. At most one ready is high per cycle.
- reqN_ready may depend on reqN_valid (arbiter). Requesters must not make valid depend on ready.
- Accept edge (valid && ready):
  - The granted operands and function drive the ALU combinationally.
  - On the edge, result, flags, rsp_id and rsp_err load into the buffer. rsp_valid=1 on the next cycle.
  - Latency is 1 cycle from accept to rsp_valid.
- Throughput is 1 op/cycle while rsp_ready stays high.
- Round-robin pointer: after a grant to requester N, the pointer becomes 1-N. The pointer is unchanged on cycles without an accept. Fairness under continuous contention is strict alternation 0,1,0,1.
- Drain: rsp_valid && rsp_ready with no new accept clears rsp_valid. Accept and drain on the same edge overwrite the buffer and rsp_valid stays 1.
- Hold: rsp_valid && !rsp_ready keeps all rsp_* stable and forces both req*_ready=0.
- ALU semantics:
  - add/sub: 32-bit two's complement.
  - carry is the 33rd sum bit; for sub it is a + ~b + 1, so carry=1 means no borrow.
  - overflow is signed overflow of add/sub.
  - and/or: carry=0 and overflow=0.
  - slt: result = {31'b0, (a<b signed)}, computed as overflow XOR sum[31] of a-b. Carry and overflow report the underlying subtraction.
  - zero = (result==0); negative = result[31].
- Illegal f: result=0, zero=1, negative=0, overflow and carry as the ALU produces them, rsp_err=1. The op is still accepted and counted.
- Grant counters increment on each accept of their requester and saturate at all-ones, with no wrap.
- Requester operand changes while not ready have no effect.
- rst_n asserting mid-hold drops the response; no partial state survives.

Test Plan:
- Reset, then req0 add a=0x00000005 b=0x00000003 -> req0_ready=1; next cycle rsp_valid=1, rsp_id=0, rsp_result=0x00000008, all flags 0, grant_cnt0=1.
- req1 sub a=b=0x00000005 -> rsp_result=0, zero=1, carry=1, overflow=0, negative=0, rsp_id=1.
- req0 add a=0x7FFFFFFF b=0x00000001 -> result 0x80000000, overflow=1, negative=1, carry=0. req1 slt a=0xFFFFFFFF b=0x00000001 -> result 0x00000001.
- Both valid for 4 cycles with rsp_ready=1, RR_EN=1 -> grants 0,1,0,1, rsp_id sequence 0,1,0,1, grant_cnt0=grant_cnt1=2. Repeat with RR_EN=0 -> all four grants to requester 0.
- rsp_ready=0 with a buffered result -> both req*_ready=0 and rsp_* stable for 3 cycles. Raising rsp_ready with req1 valid -> drain and accept on the same edge, rsp_valid stays 1 with the new result.
- Illegal f=110 -> rsp_err=1, result=0, zero=1. Assert rst_n=0 asynchronously while rsp_valid=1 -> rsp_valid=0 immediately, counters 0, next contention grants requester 0 first.
